// File: rtl/wb_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module : wb_trace_fifo
// Brief  : Show-ahead FIFO for CPU writeback trace records. It drops records
//          once full, counts the drops and flags them with a sticky bit.
// Rev    : 1.0 - initial release
// ============================================================================
module wb_trace_fifo #(
    parameter int  DEPTH     = 16,
    parameter bit  FILTER_R0 = 1'b1,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [31:0]       wb_pc,
    input  logic [3:0]        wb_we,
    input  logic [4:0]        wb_wnum,
    input  logic [31:0]       wb_wdata,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [31:0]       trace_pc,
    output logic [3:0]        trace_we,
    output logic [4:0]        trace_wnum,
    output logic [31:0]       trace_wdata,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [15:0]       drop_cnt
);

    localparam logic [ADDR_W:0] c_depth   = (ADDR_W + 1)'(DEPTH);
    localparam int              c_rec_w   = 73;

    logic [c_rec_w-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [ADDR_W:0]    r_count;
    logic               r_overflow;
    logic [15:0]        r_drop_cnt;

    logic               w_cap;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [c_rec_w-1:0] w_rec;
    logic [c_rec_w-1:0] w_head;

    assign w_rec  = {wb_pc, wb_we, wb_wnum, wb_wdata};
    assign w_cap  = (|wb_we) && ((wb_wnum != 5'd0) || !FILTER_R0);
    assign w_pop  = trace_valid && trace_ready;
    // A full FIFO still accepts a record when the head leaves in the same cycle.
    assign w_push = w_cap && ((r_count < c_depth) || w_pop);
    assign w_drop = w_cap && !w_push;

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push && !clear) begin
            r_mem[r_wr_ptr] <= w_rec;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= 16'd0;
        end else if (clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= 16'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 16'hFFFF) begin
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end
        end
    end

    assign w_head      = r_mem[r_rd_ptr];
    assign trace_valid = (r_count != '0);
    assign trace_pc    = w_head[72:41];
    assign trace_we    = w_head[40:37];
    assign trace_wnum  = w_head[36:32];
    assign trace_wdata = w_head[31:0];
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign drop_cnt    = r_drop_cnt;

endmodule
`default_nettype wire
